// File: rtl/frame_cell_loader.sv
// frame_cell_loader: per-frame raster walk that fetches each cell colour over req/ack
// and presents it to matrix_display as a one-cycle cell_en strobe.
module frame_cell_loader #(
  parameter int WIDTH      = 20,
  parameter int HEIGHT     = 15,
  parameter int B_WIDTH    = 5,
  parameter int B_HEIGHT   = 4,
  parameter int B_S_WIDTH  = 10,
  parameter int B_S_HEIGHT = 10,
  parameter int B_VGA      = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  vclock,
  input  logic                  reset,
  input  logic [B_S_WIDTH-1:0]  hcount,
  input  logic [B_S_HEIGHT-1:0] vcount,
  input  logic                  enable,
  input  logic [3*B_VGA-1:0]    background,
  output logic                  src_req,
  output logic [B_WIDTH-1:0]    src_x,
  output logic [B_HEIGHT-1:0]   src_y,
  input  logic                  src_ack,
  input  logic [3*B_VGA-1:0]    src_rgb,
  output logic [3*B_VGA-1:0]    cell_rgb,
  output logic [B_WIDTH-1:0]    cell_x,
  output logic [B_HEIGHT-1:0]   cell_y,
  output logic                  cell_en,
  output logic                  update,
  output logic                  busy,
  output logic                  overrun,
  output logic [7:0]            miss_count
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, EMIT} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [B_WIDTH-1:0] x_q, x_d, cx_q, cx_d;
  logic [B_HEIGHT-1:0] y_q, y_d, cy_q, cy_d;
  logic [3*B_VGA-1:0] rgb_q, rgb_d;
  logic [7:0] miss_q, miss_d;
  logic req_q, req_d, en_q, en_d, upd_q, upd_d, busy_q, busy_d, ovr_q, ovr_d;
  logic fs, last_x, last_y, hit;
  assign fs     = hcount == '0 && vcount == '0;
  assign last_x = x_q == B_WIDTH'(WIDTH - 1);
  assign last_y = y_q == B_HEIGHT'(HEIGHT - 1);
  assign hit    = src_ack || cnt_q == CW'(TIMEOUT);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    rgb_d   = rgb_q;
    miss_d  = miss_q;
    req_d   = req_q;
    busy_d  = busy_q;
    en_d    = 1'b0;
    upd_d   = 1'b0;
    // any frame start outside IDLE (including the final EMIT) is an overrun
    ovr_d   = ovr_q | (fs && state_q != IDLE);
    case (state_q)
      IDLE: if (fs && enable) begin
        state_d = REQ;
        upd_d   = 1'b1;
        busy_d  = 1'b1;
        req_d   = 1'b1;
        cnt_d   = '0;
        x_d     = '0;
        y_d     = '0;
      end
      REQ: if (hit) begin
        state_d = EMIT;
        req_d   = 1'b0;
        en_d    = 1'b1;
        cx_d    = x_q;
        cy_d    = y_q;
        rgb_d   = src_ack ? src_rgb : background;
        miss_d  = (src_ack || miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      EMIT: if (last_x && last_y) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        x_d     = '0;
        y_d     = '0;
      end else begin
        state_d = REQ;
        req_d   = 1'b1;
        cnt_d   = '0;
        x_d     = last_x ? '0 : x_q + B_WIDTH'(1);
        y_d     = last_x ? y_q + B_HEIGHT'(1) : y_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge vclock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      rgb_q   <= '0;
      miss_q  <= '0;
      req_q   <= 1'b0;
      en_q    <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      rgb_q   <= rgb_d;
      miss_q  <= miss_d;
      req_q   <= req_d;
      en_q    <= en_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end
  assign src_req    = req_q;
  assign src_x      = x_q;
  assign src_y      = y_q;
  assign cell_rgb   = rgb_q;
  assign cell_x     = cx_q;
  assign cell_y     = cy_q;
  assign cell_en    = en_q;
  assign update     = upd_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;
  assign miss_count = miss_q;
endmodule

// File: tb/tb_frame_cell_loader.sv
// tb_frame_cell_loader: directed passes with randomized ack delays and colours,
// checked cycle by cycle against a cell-order / ack-delay reference model.
module tb_frame_cell_loader;
  localparam int W  = 20;
  localparam int H  = 15;
  localparam int TO = 15;
  logic        vclock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  hcount = 10'd7;
  logic [9:0]  vcount = 10'd0;
  logic        enable = 1'b0;
  logic [11:0] background = 12'h0;
  logic        src_ack = 1'b0;
  logic [11:0] src_rgb = 12'h0;
  logic        src_req, cell_en, update, busy, overrun;
  logic [4:0]  src_x, cell_x;
  logic [3:0]  src_y, cell_y;
  logic [11:0] cell_rgb;
  logic [7:0]  miss_count;
  int errors = 0;
  int checks = 0;
  int cyc = 1000;
  int fs_at = -1;
  int drop_at = -1;
  bit fs_force = 1'b0;
  bit exp_ovr = 1'b0;
  int exp_miss = 0;

  frame_cell_loader dut (
    .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount),
    .enable(enable), .background(background), .src_req(src_req),
    .src_x(src_x), .src_y(src_y), .src_ack(src_ack), .src_rgb(src_rgb),
    .cell_rgb(cell_rgb), .cell_x(cell_x), .cell_y(cell_y), .cell_en(cell_en),
    .update(update), .busy(busy), .overrun(overrun), .miss_count(miss_count)
  );

  always #5 vclock = ~vclock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive frame-start/enable for the current cycle, advance, sample #1 later.
  task automatic tick();
    hcount = (cyc == 0 || cyc == fs_at || fs_force) ? 10'd0 : 10'd7;
    vcount = 10'd0;
    if (cyc == drop_at) enable = 1'b0;
    @(posedge vclock);
    #1;
    if (cyc == fs_at) exp_ovr = 1'b1;
    cyc++;
    chk("update", 32'(update), 32'(cyc == 1));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  // mode 0: fixed ack delay dly (dly > TO means stuck); mode 1: random delay per cell
  task automatic run_pass(input int mode, input int dly);
    int d, x, y, w;
    bit acked;
    logic [11:0] rgb;
    cyc = 0;
    enable = 1'b1;
    src_ack = 1'b0;
    tick();
    chk("busy_start", 32'(busy), 32'd1);
    for (int n = 0; n < W * H; n++) begin
      x = n % W;
      y = n / W;
      d = (mode == 1) ? int'($urandom_range(0, TO + 3)) : dly;
      rgb = 12'h0;
      for (w = 0; w <= TO; w++) begin
        chk("src_req", 32'(src_req), 32'd1);
        chk("src_x", 32'(src_x), 32'(x));
        chk("src_y", 32'(src_y), 32'(y));
        chk("cell_en_idle", 32'(cell_en), 32'd0);
        chk("busy", 32'(busy), 32'd1);
        rgb = (mode == 0 && dly == 0) ? 12'((x << 8) | (y << 4)) : 12'($urandom);
        src_rgb = rgb;
        src_ack = (w == d);
        tick();
        if (w == d) break;
      end
      acked = d <= TO;
      if (!acked) exp_miss = (exp_miss < 255) ? exp_miss + 1 : 255;
      chk("cell_en", 32'(cell_en), 32'd1);
      chk("cell_x", 32'(cell_x), 32'(x));
      chk("cell_y", 32'(cell_y), 32'(y));
      chk("cell_rgb", 32'(cell_rgb), 32'(acked ? rgb : background));
      chk("req_drop", 32'(src_req), 32'd0);
      chk("miss_count", 32'(miss_count), 32'(exp_miss));
      src_ack = 1'($urandom);
      src_rgb = 12'($urandom);
      tick();
    end
    if (mode == 0 && dly == 0) chk("end_cycle", 32'(cyc), 32'd601);
    chk("busy_end", 32'(busy), 32'd0);
    chk("cell_en_end", 32'(cell_en), 32'd0);
    chk("cell_x_hold", 32'(cell_x), 32'(W - 1));
    chk("cell_y_hold", 32'(cell_y), 32'(H - 1));
    chk("src_x_rewind", 32'(src_x), 32'd0);
    chk("src_y_rewind", 32'(src_y), 32'd0);
    src_ack = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_req", 32'(src_req), 32'd0);
      chk("idle_en", 32'(cell_en), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    src_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge vclock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(src_req), 32'd0);
    chk("rst_miss", 32'(miss_count), 32'd0);
    reset = 1'b1;
    tick();
    background = 12'h5A3;
    run_pass(0, 0);
    run_pass(0, 3);
    enable = 1'b0;
    fs_force = 1'b1;
    repeat (3) begin
      tick();
      chk("dis_req", 32'(src_req), 32'd0);
      chk("dis_busy", 32'(busy), 32'd0);
    end
    fs_force = 1'b0;
    drop_at = 50;
    run_pass(0, 1);
    drop_at = -1;
    background = 12'($urandom);
    run_pass(1, 0);
    background = 12'hF0F;
    run_pass(0, 99);
    chk("miss_sat", 32'(miss_count), 32'd255);
    fs_at = 300;
    run_pass(0, 0);
    fs_at = -1;
    cyc = 0;
    enable = 1'b1;
    src_ack = 1'b1;
    repeat (100) tick();
    #3 reset = 1'b0;
    #1;
    exp_ovr = 1'b0;
    exp_miss = 0;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_req", 32'(src_req), 32'd0);
    chk("ar_src_xy", 32'({src_x, src_y}), 32'd0);
    chk("ar_cell", 32'({cell_en, cell_x, cell_y, cell_rgb}), 32'd0);
    chk("ar_ovr", 32'(overrun), 32'd0);
    chk("ar_miss", 32'(miss_count), 32'd0);
    cyc = 1000;
    src_ack = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    run_pass(0, 0);
    fs_at = 600;
    run_pass(0, 0);
    fs_at = -1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
